// File: rtl/m2vside_fifo.sv
// Stage-2 side-info FIFO: DEPTH records pushed by m2vside1, popped into registered s2_* outputs on block_start.
// One-clock pop latency; no backpressure (push when full drops and flags overflow); optional M2VSIDE_FIFO_BYPASS_EN.
module m2vside_fifo #(
  parameter int MVH_WIDTH  = 16,
  parameter int MVV_WIDTH  = 15,
  parameter int MBX_WIDTH  = 6,
  parameter int MBY_WIDTH  = 5,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [MVH_WIDTH-1:0]  s1_mv_h,
  input  logic [MVV_WIDTH-1:0]  s1_mv_v,
  input  logic [MBX_WIDTH-1:0]  s1_mb_x,
  input  logic [MBY_WIDTH-1:0]  s1_mb_y,
  input  logic                  s1_mb_intra,
  input  logic [2:0]            s1_block,
  input  logic                  s1_coded,
  input  logic                  s1_push,
  input  logic                  block_start,
  input  logic                  flush,
  output logic [MVH_WIDTH-1:0]  s2_mv_h,
  output logic [MVV_WIDTH-1:0]  s2_mv_v,
  output logic [MBX_WIDTH-1:0]  s2_mb_x,
  output logic [MBY_WIDTH-1:0]  s2_mb_y,
  output logic                  s2_mb_intra,
  output logic [2:0]            s2_block,
  output logic                  s2_coded,
  output logic                  s2_enable,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef struct packed {
    logic [MVH_WIDTH-1:0] mv_h;
    logic [MVV_WIDTH-1:0] mv_v;
    logic [MBX_WIDTH-1:0] mb_x;
    logic [MBY_WIDTH-1:0] mb_y;
    logic                 mb_intra;
    logic [2:0]           block;
    logic                 coded;
  } rec_t;

  rec_t                  mem_q [DEPTH];
  rec_t                  mem_d [DEPTH];
  rec_t                  s2_q, s2_d;
  rec_t                  in_rec;
  logic                  s2_enable_q, s2_enable_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  pop_ok, push_ok, bypass;

  assign in_rec = '{mv_h: s1_mv_h, mv_v: s1_mv_v, mb_x: s1_mb_x, mb_y: s1_mb_y,
                    mb_intra: s1_mb_intra, block: s1_block, coded: s1_coded};

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef M2VSIDE_FIFO_BYPASS_EN
  assign bypass = empty & s1_push & block_start;
`else
  assign bypass = 1'b0;
`endif

  // A pop from a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = block_start & ~empty;
  assign push_ok = s1_push & (~full | pop_ok);

  always_comb begin
    mem_d         = mem_q;
    s2_d          = s2_q;
    s2_enable_d   = s2_enable_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      s2_enable_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (bypass) begin
      s2_d        = in_rec;
      s2_enable_d = 1'b1;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = in_rec;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end else if (s1_push) begin
        overflow_d = 1'b1;
      end
      if (pop_ok) begin
        s2_d        = mem_q[rd_ptr_q];
        s2_enable_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
      end else if (block_start) begin
        s2_enable_d = 1'b0;
        underflow_d = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      s2_q        <= '0;
      s2_enable_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      s2_q        <= s2_d;
      s2_enable_q <= s2_enable_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign s2_mv_h     = s2_q.mv_h;
  assign s2_mv_v     = s2_q.mv_v;
  assign s2_mb_x     = s2_q.mb_x;
  assign s2_mb_y     = s2_q.mb_y;
  assign s2_mb_intra = s2_q.mb_intra;
  assign s2_block    = s2_q.block;
  assign s2_coded    = s2_q.coded;
  assign s2_enable   = s2_enable_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
